// File: rtl/day_of_year_calc.sv
// Sequential calendar-date to day-of-year converter. The date arrives as a binary
// month, BCD day digits and a leap flag; one month length is accumulated per clock.
module day_of_year_calc (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_leap,
  input  logic [3:0] i_month,
  input  logic [3:0] i_day1,
  input  logic [3:0] i_day2,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [8:0] o_doy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_month;
  logic [3:0] r_day1;
  logic [3:0] r_day2;
  logic       r_leap;
  logic [8:0] r_acc;
  logic [3:0] r_m;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic [8:0] r_doy;

  logic [5:0] w_day;
  logic [4:0] w_len_req;
  logic [4:0] w_len_m;
  logic       w_invalid;

  // Length of month m; out-of-range months yield 0 so every day compares as too large.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    logic [4:0] len;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
      4'd2:    len = leap ? 5'd29 : 5'd28;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

  assign w_day     = ({2'b00, r_day1} * 6'd10) + {2'b00, r_day2};
  assign w_len_req = month_len(r_month, r_leap);
  assign w_len_m   = month_len(r_m, r_leap);
  assign w_invalid = (r_day1 > 4'd3) || (r_day2 > 4'd9) ||
                     (r_month == 4'd0) || (r_month > 4'd12) ||
                     (w_day == 6'd0) || (w_day > {1'b0, w_len_req});

  // Control FSM; done/doy/err are loaded on the edge that enters DONE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_month <= 4'd0;
      r_day1  <= 4'd0;
      r_day2  <= 4'd0;
      r_leap  <= 1'b0;
      r_acc   <= 9'd0;
      r_m     <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_doy   <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_month <= i_month;
            r_day1  <= i_day1;
            r_day2  <= i_day2;
            r_leap  <= i_leap;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_invalid) begin
            r_err   <= 1'b1;
            r_doy   <= 9'd0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_acc   <= {3'b000, w_day};
            r_m     <= 4'd1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (r_m == r_month) begin
            r_doy   <= r_acc;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_acc <= r_acc + {4'b0000, w_len_m};
            r_m   <= r_m + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_doy  = r_doy;

endmodule

// File: tb/tb_day_of_year_calc.sv
// Self-checking bench for day_of_year_calc: a vector table run through a
// scoreboard, plus hand-written handshake and mid-operation reset sequences.
module tb_day_of_year_calc;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic       i_leap;
  logic [3:0] i_month;
  logic [3:0] i_day1;
  logic [3:0] i_day2;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [8:0] o_doy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] month;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       leap;
    int         doy;
    int         err;
    int         lat;
  } vec_t;

  typedef struct {
    int doy;
    int err;
    int lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  day_of_year_calc dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_leap  (i_leap),
    .i_month (i_month),
    .i_day1  (i_day1),
    .i_day2  (i_day2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_doy   (o_doy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge after done has dropped.
  task automatic run_req(input string nm, input vec_t v);
    exp_t e;
    int   cyc;
    bit   seen;
    i_month = v.month;
    i_day1  = v.d1;
    i_day2  = v.d2;
    i_leap  = v.leap;
    i_start = 1'b1;
    e.doy = v.doy;
    e.err = v.err;
    e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    check({nm, "_busy_rise"}, int'(o_busy), 1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    if (!seen) begin
      check({nm, "_done_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({nm, "_doy"}, int'(o_doy), e.doy);
      check({nm, "_err"}, int'(o_err), e.err);
      check({nm, "_latency"}, cyc, e.lat);
      check({nm, "_busy_in_done"}, int'(o_busy), 1);
      @(posedge clk);
      @(negedge clk);
      check({nm, "_done_drop"}, int'(o_done), 0);
      check({nm, "_busy_drop"}, int'(o_busy), 0);
    end
  endtask

  initial begin
    exp_t e;
    vec_t v;
    int   n_done;
    int   hs_doy;
    int   hs_lat;

    vecs[0]  = '{4'd1,  4'd0, 4'd1,  1'b0, 1,   0, 2};
    vecs[1]  = '{4'd3,  4'd0, 4'd1,  1'b1, 61,  0, 4};
    vecs[2]  = '{4'd3,  4'd0, 4'd1,  1'b0, 60,  0, 4};
    vecs[3]  = '{4'd12, 4'd3, 4'd1,  1'b1, 366, 0, 13};
    vecs[4]  = '{4'd12, 4'd3, 4'd1,  1'b0, 365, 0, 13};
    vecs[5]  = '{4'd2,  4'd2, 4'd9,  1'b0, 0,   1, 1};
    vecs[6]  = '{4'd4,  4'd3, 4'd1,  1'b0, 0,   1, 1};
    vecs[7]  = '{4'd5,  4'd1, 4'd10, 1'b0, 0,   1, 1};
    vecs[8]  = '{4'd0,  4'd0, 4'd1,  1'b0, 0,   1, 1};
    vecs[9]  = '{4'd13, 4'd0, 4'd1,  1'b0, 0,   1, 1};
    vecs[10] = '{4'd1,  4'd0, 4'd0,  1'b0, 0,   1, 1};
    vecs[11] = '{4'd2,  4'd2, 4'd9,  1'b1, 60,  0, 3};
    vecs[12] = '{4'd7,  4'd0, 4'd4,  1'b0, 185, 0, 8};
    vecs[13] = '{4'd4,  4'd3, 4'd0,  1'b1, 121, 0, 5};

    i_reset = 1'b0;
    i_start = 1'b0;
    i_leap  = 1'b0;
    i_month = 4'd0;
    i_day1  = 4'd0;
    i_day2  = 4'd0;
    #3 i_reset = 1'b1;
    #1;
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_err",  int'(o_err),  0);
    check("reset_doy",  int'(o_doy),  0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i]);
    end

    // Start held for 5 edges during a June request: exactly one result.
    i_month = 4'd6;
    i_day1  = 4'd1;
    i_day2  = 4'd5;
    i_leap  = 1'b0;
    i_start = 1'b1;
    e.doy = 166;
    e.err = 0;
    e.lat = 7;
    sb.push_back(e);
    n_done = 0;
    hs_doy = -1;
    hs_lat = -1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 4) i_start = 1'b0;
      if (o_done) begin
        n_done++;
        if (n_done == 1) begin
          hs_doy = int'(o_doy);
          hs_lat = i;
        end
      end
    end
    e = sb.pop_front();
    check("hs_done_count", n_done, 1);
    check("hs_doy", hs_doy, e.doy);
    check("hs_latency", hs_lat, e.lat);
    check("hs_doy_held", int'(o_doy), e.doy);
    check("hs_busy_idle", int'(o_busy), 0);
    v = '{4'd1, 4'd0, 4'd1, 1'b0, 1, 0, 2};
    run_req("hs_next", v);

    // Reset in the third ACCUM cycle of a September request.
    i_month = 4'd9;
    i_day1  = 4'd3;
    i_day2  = 4'd0;
    i_leap  = 1'b0;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 i_reset = 1'b1;
    #1;
    check("abort_busy", int'(o_busy), 0);
    check("abort_done", int'(o_done), 0);
    check("abort_err",  int'(o_err),  0);
    check("abort_doy",  int'(o_doy),  0);
    @(negedge clk);
    i_reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    v = '{4'd9, 4'd3, 4'd0, 1'b0, 273, 0, 10};
    run_req("after_abort", v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
